// File: rtl/proximity_debounce.sv
// -----------------------------------------------------------------------------
// proximity_debounce
//
// Conditioning stage for the IR proximity sensor pin, placed in front of the
// proximity_sensor reader. The asynchronous pin is brought into the clk domain
// through a two-flop synchroniser. A stable-time filter then accepts a level
// change only after the synchronised level has held for DB_CYCLES clocks. The
// block produces a clean level and one-cycle rise/fall event pulses.
//
// Optional feature (compile-time macro PROX_EVENT_COUNT_EN):
//   defined   : count tracks accepted rise events (wraps modulo 2^CNT_W),
//               clr_count clears it synchronously.
//   undefined : no counter logic, count is tied to 0 and clr_count is unused.
//
// Parameters
//   CLK_HZ       system clock frequency in Hz
//   DEBOUNCE_MS  stable time in ms required before a level change is accepted
//   CNT_W        event counter width
//   DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS must be >= 1.
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst_n      in   1      asynchronous active-low reset
//   pin        in   1      raw sensor pin (async to clk), 1 = object present
//   enable     in   1      1 = filter runs, 0 = idle with outputs low
//   clr_count  in   1      synchronous clear of the event counter
//   value      out  1      debounced level
//   rise       out  1      one-cycle pulse on value 0->1
//   fall       out  1      one-cycle pulse on value 1->0
//   count      out  CNT_W  number of accepted rise events
// -----------------------------------------------------------------------------
module proximity_debounce #(
    parameter int CLK_HZ      = 12_000_000,
    parameter int DEBOUNCE_MS = 5,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pin,
    input  logic             enable,
    input  logic             clr_count,
    output logic             value,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] count
);

    localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int TIMER_W   = $clog2(DB_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ARM_HI = 3'd2,
        DETECT = 3'd3,
        ARM_LO = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nx;
    logic                 value_nx;
    logic                 rise_nx;
    logic                 fall_nx;

    logic                 s1;
    logic                 s;

    // --- synchroniser: pin -> s1 -> s ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= pin;
            s  <= s1;
        end
    end

    // --- filter state register; outputs are registered so pulses are glitch-free ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            value <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            value <= value_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        value_nx = value;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;

        // Dropping enable abandons any debounce in progress silently: the
        // level is forced low without a fall event.
        if (!enable) begin
            state_nx = IDLE;
            timer_nx = '0;
            value_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = CLEAR;
                    timer_nx = '0;
                    value_nx = 1'b0;
                end

                CLEAR: begin
                    value_nx = 1'b0;
                    if (s) begin
                        state_nx = ARM_HI;
                        timer_nx = '0;
                    end
                end

                ARM_HI: begin
                    if (!s) begin
                        state_nx = CLEAR;
                        timer_nx = '0;
                    end else if (timer == TIMER_LAST) begin
                        state_nx = DETECT;
                        timer_nx = '0;
                        value_nx = 1'b1;
                        rise_nx  = 1'b1;
                    end else begin
                        timer_nx = timer + TIMER_W'(1);
                    end
                end

                DETECT: begin
                    value_nx = 1'b1;
                    if (!s) begin
                        state_nx = ARM_LO;
                        timer_nx = '0;
                    end
                end

                ARM_LO: begin
                    if (s) begin
                        state_nx = DETECT;
                        timer_nx = '0;
                    end else if (timer == TIMER_LAST) begin
                        state_nx = CLEAR;
                        timer_nx = '0;
                        value_nx = 1'b0;
                        fall_nx  = 1'b1;
                    end else begin
                        timer_nx = timer + TIMER_W'(1);
                    end
                end

                default: begin
                    state_nx = IDLE;
                    timer_nx = '0;
                    value_nx = 1'b0;
                end
            endcase
        end
    end

`ifdef PROX_EVENT_COUNT_EN
    // --- event counter: follows the registered rise pulse one clock later ---
    // A clear coinciding with a rise pulse still records that event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr_count) begin
            count <= CNT_W'(rise);
        end else begin
            count <= count + CNT_W'(rise);
        end
    end
`else
    logic unused_clr_count;
    assign unused_clr_count = clr_count;
    assign count            = '0;
`endif

endmodule
